// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives one outstanding imem request at a time, holds the
// fetched word in IR until decode accepts it, and handles branch redirects.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [9:0]  xox,
    output logic [8:0]  xoxo,
    output logic [1:0]  xods
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state;
    logic        req;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pc_held;
    logic [31:0] target;
    logic [31:0] redir_aligned;

    assign redir_aligned = {redirect_target[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RESET;
            req     <= 1'b0;
            valid   <= 1'b0;
            pc      <= RESET_PC;
            ir      <= '0;
            pc_held <= RESET_PC;
            target  <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_FETCH;
                    req   <= 1'b1;
                end
                S_FETCH: begin
                    if (redirect_valid) begin
                        // Without an ack the request must stay on the bus unchanged,
                        // so the target waits in FLUSH until that stale ack arrives.
                        if (imem_ack) begin
                            pc    <= redir_aligned;
                            state <= S_FETCH;
                        end else begin
                            target <= redir_aligned;
                            state  <= S_FLUSH;
                        end
                        req   <= 1'b1;
                        valid <= 1'b0;
                    end else if (imem_ack) begin
                        ir      <= imem_rdata;
                        pc_held <= pc;
                        valid   <= 1'b1;
                        req     <= 1'b0;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redir_aligned;
                        valid <= 1'b0;
                        req   <= 1'b1;
                        state <= S_FETCH;
                    end else if (instr_ready) begin
                        pc    <= pc + 32'd4;
                        valid <= 1'b0;
                        req   <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (imem_ack) begin
                        pc    <= redirect_valid ? redir_aligned : target;
                        state <= S_FETCH;
                    end else if (redirect_valid) begin
                        target <= redir_aligned;
                    end
                    req   <= 1'b1;
                    valid <= 1'b0;
                end
                default: begin
                    state <= S_RESET;
                    req   <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc;
    assign instr_valid = valid;
    assign instr       = ir;
    assign pc_out      = pc_held;
    assign opcode      = ir[31:26];
    assign xox         = ir[10:1];
    assign xoxo        = ir[9:1];
    assign xods        = ir[1:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the fetch protocol.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_ready;

    logic        req_a, valid_a, req_b, valid_b;
    logic [31:0] addr_a, instr_a, pcout_a, addr_b, instr_b, pcout_b;
    logic [5:0]  opc_a, opc_b;
    logic [9:0]  xox_a, xox_b;
    logic [8:0]  xoxo_a, xoxo_b;
    logic [1:0]  xods_a, xods_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_ready(instr_ready), .instr_valid(valid_a), .instr(instr_a), .pc_out(pcout_a),
        .opcode(opc_a), .xox(xox_a), .xoxo(xoxo_a), .xods(xods_a)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_ready(instr_ready), .instr_valid(valid_b), .instr(instr_b), .pc_out(pcout_b),
        .opcode(opc_b), .xox(xox_b), .xoxo(xoxo_b), .xods(xods_b)
    );

    // idle: first cycle after reset; have: word held for decode;
    // stale: outstanding request whose data will be thrown away, nxt = where to go after.
    typedef struct {
        bit          idle;
        bit          have;
        bit          stale;
        logic [31:0] addr;
        logic [31:0] nxt;
        logic [31:0] ir;
        logic [31:0] pcout;
    } model_t;

    model_t m [2];
    logic [31:0] rpc [2];

    task automatic model_step(input int k);
        logic [31:0] tgt;
        tgt = redirect_target & 32'hFFFF_FFFC;
        if (rst) begin
            m[k].idle = 1; m[k].have = 0; m[k].stale = 0;
            m[k].addr = rpc[k]; m[k].nxt = 0; m[k].ir = 0; m[k].pcout = rpc[k];
        end else if (m[k].idle) begin
            m[k].idle = 0;
        end else if (m[k].have) begin
            if (redirect_valid) begin
                m[k].have = 0; m[k].addr = tgt;
            end else if (instr_ready) begin
                m[k].have = 0; m[k].addr = m[k].addr + 4;
            end
        end else if (m[k].stale) begin
            if (imem_ack) begin
                m[k].addr = redirect_valid ? tgt : m[k].nxt;
                m[k].stale = 0;
            end else if (redirect_valid) begin
                m[k].nxt = tgt;
            end
        end else begin
            if (redirect_valid) begin
                if (imem_ack) m[k].addr = tgt;
                else begin m[k].stale = 1; m[k].nxt = tgt; end
            end else if (imem_ack) begin
                m[k].have = 1; m[k].ir = imem_rdata; m[k].pcout = m[k].addr;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] ir;
        ir = m[0].ir;
        chk("a.req",   req_a,   32'(!m[0].idle && !m[0].have));
        chk("a.addr",  addr_a,  m[0].addr);
        chk("a.valid", valid_a, 32'(m[0].have));
        chk("a.instr", instr_a, ir);
        chk("a.pcout", pcout_a, m[0].pcout);
        chk("a.opcode", opc_a,  ir >> 26);
        chk("a.xox",   xox_a,   (ir >> 1) % 1024);
        chk("a.xoxo",  xoxo_a,  (ir >> 1) % 512);
        chk("a.xods",  xods_a,  ir % 4);
        chk("b.req",   req_b,   32'(!m[1].idle && !m[1].have));
        chk("b.addr",  addr_b,  m[1].addr);
        chk("b.valid", valid_b, 32'(m[1].have));
        chk("b.instr", instr_b, m[1].ir);
        chk("b.pcout", pcout_b, m[1].pcout);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    logic [31:0] snap_ir, snap_pc;

    initial begin
        rpc[0] = 32'h0000_0000;
        rpc[1] = 32'hFFFF_FFFC;
        for (int k = 0; k < 2; k++) m[k] = '{1, 0, 0, rpc[k], 0, 0, rpc[k]};
        rst = 1; imem_ack = 0; imem_rdata = 0; redirect_valid = 0;
        redirect_target = 0; instr_ready = 0;
        repeat (3) cycle();
        chk("rst.req", req_a, 0);
        chk("rst.addr", addr_a, 32'h0);
        chk("rst.instr", instr_a, 32'h0);

        // Basic fetch with ack in the first FETCH cycle
        rst = 0;
        cycle();
        chk("f1.req", req_a, 1);
        chk("f1.addr_b", addr_b, 32'hFFFF_FFFC);
        imem_ack = 1; imem_rdata = 32'h7C64_2214; instr_ready = 1;
        cycle();
        chk("f1.valid", valid_a, 1);
        chk("f1.pcout", pcout_a, 32'h0);
        chk("f1.opcode", opc_a, 31);
        chk("f1.xox", xox_a, 266);
        chk("f1.xoxo", xoxo_a, 266);
        chk("f1.xods", xods_a, 0);
        imem_ack = 0;
        cycle();
        chk("f1.next_addr", addr_a, 32'h4);
        chk("wrap.next_addr_b", addr_b, 32'h0);

        // Stall in HOLD
        instr_ready = 0; imem_ack = 1; imem_rdata = $urandom;
        cycle();
        imem_ack = 0;
        snap_ir = instr_a; snap_pc = pcout_a;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold.req", req_a, 0);
            chk("hold.valid", valid_a, 1);
            chk("hold.instr", instr_a, snap_ir);
            chk("hold.pcout", pcout_a, snap_pc);
        end
        instr_ready = 1;
        cycle();
        chk("hold.next_addr", addr_a, 32'h8);
        instr_ready = 0;

        // Redirect in FETCH with delayed ack
        redirect_valid = 1; redirect_target = 32'h0000_0103;
        cycle();
        redirect_valid = 0; redirect_target = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("flush.addr", addr_a, 32'h8);
            chk("flush.req", req_a, 1);
            chk("flush.valid", valid_a, 0);
        end
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        imem_ack = 0;
        chk("flush.new_addr", addr_a, 32'h100);
        chk("flush.discard", valid_a, 0);

        // Redirect beats instr_ready in HOLD
        imem_ack = 1; imem_rdata = $urandom;
        cycle();
        imem_ack = 0;
        redirect_valid = 1; redirect_target = 32'h0000_0200; instr_ready = 1;
        cycle();
        redirect_valid = 0; instr_ready = 0;
        chk("hredir.valid", valid_a, 0);
        chk("hredir.addr", addr_a, 32'h200);

        // Reset during FLUSH followed by a stray ack
        redirect_valid = 1; redirect_target = 32'h0000_0300;
        cycle();
        redirect_valid = 0;
        rst = 1;
        cycle();
        chk("rflush.req", req_a, 0);
        chk("rflush.addr", addr_a, 32'h0);
        rst = 0; imem_ack = 1; imem_rdata = 32'h1234_5678;
        cycle();
        imem_ack = 0;
        chk("rflush.valid", valid_a, 0);
        chk("rflush.instr", instr_a, 32'h0);
        chk("rflush.restart", addr_a, 32'h0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst             = ($urandom_range(0, 99) == 0);
            imem_ack        = ($urandom_range(0, 9) < 4);
            imem_rdata      = $urandom;
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom;
            instr_ready     = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, word-aligned PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory request, held until acknowledged.
REQ-005 imem_addr  output  32  fetch address, stable while imem_req=1.
REQ-006 imem_ack  input  1  memory acknowledge; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 redirect_valid  input  1  one-cycle branch redirect pulse from execute.
REQ-009 redirect_target  input  32  branch target PC.
REQ-010 instr_ready  input  1  downstream (decode/control) accepts the held instruction.
REQ-011 instr_valid  output  1  IR holds an instruction awaiting acceptance.
REQ-012 instr  output  32  instruction register (IR).
REQ-013 pc_out  output  32  PC of the instruction in IR.
REQ-014 opcode  output  6  IR[31:26] (primary opcode).
REQ-015 xox  output  10  IR[10:1] (X-form extended opcode).
REQ-016 xoxo  output  9  IR[9:1] (XO-form extended opcode).
REQ-017 xods  output  2  IR[1:0] (DS-form extended opcode).

Function
REQ-018 The FSM SHALL have states RESET, FETCH, HOLD, FLUSH; imem_req=1 exactly in FETCH and FLUSH (Moore output).
REQ-019 RESET -> FETCH unconditionally on the first edge with rst=0.
REQ-020 FETCH: imem_addr=pc; on imem_ack=1, IR<=imem_rdata, pc_out<=pc, instr_valid<=1, go HOLD; ack in the first FETCH cycle SHALL be honoured (minimum latency 1 cycle from req to valid).
REQ-021 HOLD: imem_req=0; IR, pc_out and instr_valid held stable; on instr_ready=1, instr_valid<=0, pc<=pc+4, go FETCH.
REQ-022 The PC increment SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000).
REQ-023 Redirect SHALL take priority over every other event in FETCH, HOLD and FLUSH; the target SHALL be latched with bits [1:0] forced to 0.
REQ-024 Redirect in HOLD, or in FETCH together with imem_ack: discard the ack data, instr_valid<=0, pc<=target, go FETCH; an instr_ready asserted in the same cycle has no effect.
REQ-025 Redirect in FETCH without imem_ack: go FLUSH; imem_req remains 1 and imem_addr remains the old PC until the ack (the request SHALL NOT be withdrawn or modified).
REQ-026 FLUSH: on imem_ack, discard the data, pc<=latched target, go FETCH; a new redirect in FLUSH replaces the latched target and still waits for the ack.
REQ-027 In FLUSH and FETCH, instr_valid SHALL be 0.
REQ-028 opcode/xox/xoxo/xods SHALL be pure combinational slices of IR; only IR is registered.
REQ-029 redirect_valid during RESET or while rst=1 SHALL be ignored.

Reset
REQ-030 On any edge with rst=1: state<=RESET, pc<=RESET_PC, IR<=0, pc_out<=RESET_PC, instr_valid<=0, latched target<=0.
REQ-031 During and one cycle after reset: imem_req=0, imem_addr=RESET_PC, all field outputs 0.
REQ-032 Reset asserted mid-request (FETCH/FLUSH) SHALL drop imem_req on the next edge; any later imem_ack in RESET SHALL be ignored.

Verification
REQ-033 Reset, then ack in the first FETCH cycle with rdata=32'h7C64_2214, instr_ready=1 -> instr_valid=1, pc_out=0, opcode=31, xox=266, xoxo=266, xods=0; next imem_addr=4.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> IR, pc_out and instr_valid constant; imem_req=0 throughout.
REQ-035 Redirect to 32'h0000_0103 in FETCH, ack delayed 3 cycles -> imem_addr stays at the old PC until the ack, the data is discarded, the next FETCH uses 32'h0000_0100.
REQ-036 Redirect with instr_ready=1 in HOLD -> instruction not counted as accepted, pc=target, no pc+4.
REQ-037 RESET_PC=32'hFFFF_FFFC, fetch and accept -> second fetch address 32'h0000_0000.
REQ-038 rst pulse while in FLUSH, followed by a stray ack -> outputs at reset values, no instr_valid, fetch restarts at RESET_PC.
